mem_arbiter: RTL and testbench

- Shares one unified memory port between the CPU's instruction-fetch side and data (load/store) side.
- Each side sees a req/ack handshake: it holds its request until a one-cycle ack and uses the ack as its stall-release.
- Ties are broken round-robin, and a bus timeout guards against a memory that never acknowledges.
- Sits between the cpu top level and the memory model/bus.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single memory port.
// Round-robin tie-break, one-cycle ack per transaction, bus-timeout abort.
module mem_arbiter #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [XLEN-1:0] i_addr,
    output logic            i_ack,
    output logic [XLEN-1:0] i_rdata,
    output logic            i_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [1:0]      d_word,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_ack,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_err,
    output logic            m_req,
    output logic            m_we,
    output logic [1:0]      m_word,
    output logic [XLEN-1:0] m_addr,
    output logic [XLEN-1:0] m_wdata,
    input  logic [XLEN-1:0] m_rdata,
    input  logic            m_ack
);

    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        GR_I = 1'b0,
        GR_D = 1'b1
    } grant_t;

    state_t          state_q, state_d;
    grant_t          last_grant_q, last_grant_d;
    grant_t          winner_q, winner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [1:0]      word_q, word_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GR_D;
            winner_q     <= GR_I;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            word_q       <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        word_d       = word_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_d        = err_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_req || d_req) begin
                    // Tie goes to the side that did not win last time
                    if (i_req && d_req) begin
                        winner_d = (last_grant_q == GR_D) ? GR_I : GR_D;
                    end else begin
                        winner_d = i_req ? GR_I : GR_D;
                    end
                    last_grant_d = winner_d;
                    state_d      = ST_BUSY;
                    if (winner_d == GR_I) begin
                        addr_d  = i_addr;
                        we_d    = 1'b0;
                        word_d  = 2'b10;
                        wdata_d = '0;
                    end else begin
                        addr_d  = d_addr;
                        we_d    = d_we;
                        word_d  = d_word;
                        wdata_d = d_wdata;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CW'(1);
                // m_ack takes priority over a coincident timeout
                if (m_ack) begin
                    rdata_d = we_q ? '0 : m_rdata;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic busy;
    logic resp;
    assign busy = (state_q == ST_BUSY);
    assign resp = (state_q == ST_RESP);

    assign m_req   = busy;
    assign m_we    = busy & we_q;
    assign m_word  = busy ? word_q : 2'b00;
    assign m_addr  = busy ? addr_q : '0;
    assign m_wdata = busy ? wdata_q : '0;

    assign i_ack   = resp & (winner_q == GR_I);
    assign i_rdata = i_ack ? rdata_q : '0;
    assign i_err   = i_ack & err_q;
    assign d_ack   = resp & (winner_q == GR_D);
    assign d_rdata = d_ack ? rdata_q : '0;
    assign d_err   = d_ack & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, round-robin, store, timeout, mid-transaction reset.
module tb_mem_arbiter;

    localparam int unsigned XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_ack;
    logic [XLEN-1:0] i_rdata;
    logic            i_err;
    logic            d_req;
    logic            d_we;
    logic [1:0]      d_word;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_ack;
    logic [XLEN-1:0] d_rdata;
    logic            d_err;
    logic            m_req;
    logic            m_we;
    logic [1:0]      m_word;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_wdata;
    logic [XLEN-1:0] m_rdata;
    logic            m_ack;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_word(d_word), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_word(m_word), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cycles;
        rst = 1'b1; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_word = 2'b00; d_addr = '0; d_wdata = '0;
        m_rdata = '0; m_ack = 1'b0;

        // Reset, then idle
        step(); step();
        chk("rst_m_req",   64'(m_req),   64'd0);
        chk("rst_i_ack",   64'(i_ack),   64'd0);
        chk("rst_d_ack",   64'(d_ack),   64'd0);
        chk("rst_i_err",   64'(i_err),   64'd0);
        chk("rst_d_err",   64'(d_err),   64'd0);
        chk("rst_m_we",    64'(m_we),    64'd0);
        chk("rst_m_word",  64'(m_word),  64'd0);
        chk("rst_m_addr",  m_addr,       64'd0);
        chk("rst_m_wdata", m_wdata,      64'd0);
        chk("rst_i_rdata", i_rdata,      64'd0);
        chk("rst_d_rdata", d_rdata,      64'd0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("idle_m_req", 64'(m_req), 64'd0);
        end

        // Single fetch, m_ack in first BUSY cycle
        i_req = 1'b1; i_addr = 64'h1000;
        step();
        chk("fetch_m_req",  64'(m_req),  64'd1);
        chk("fetch_m_addr", m_addr,      64'h1000);
        chk("fetch_m_we",   64'(m_we),   64'd0);
        chk("fetch_m_word", 64'(m_word), 64'd2);
        m_ack = 1'b1; m_rdata = 64'h13;
        step();
        chk("fetch_i_ack",   64'(i_ack),  64'd1);
        chk("fetch_i_rdata", i_rdata,     64'h13);
        chk("fetch_i_err",   64'(i_err),  64'd0);
        chk("fetch_d_ack",   64'(d_ack),  64'd0);
        chk("fetch_resp_m_req", 64'(m_req), 64'd0);
        m_ack = 1'b0; i_req = 1'b0;
        step();
        chk("fetch_ack_width", 64'(i_ack), 64'd0);

        // Contention after reset: I, D, I, D with one-cycle memory delay
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_req = 1'b1; i_addr = 64'h1000;
        d_req = 1'b1; d_we = 1'b0; d_word = 2'b11; d_addr = 64'h2000;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_m_req",  64'(m_req), 64'd1);
            chk("rr_m_addr", m_addr, (k % 2 == 0) ? 64'h1000 : 64'h2000);
            step();
            chk("rr_m_addr_hold", m_addr, (k % 2 == 0) ? 64'h1000 : 64'h2000);
            m_ack = 1'b1; m_rdata = 64'hA000 + 64'(k);
            step();
            m_ack = 1'b0;
            chk("rr_i_ack", 64'(i_ack), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_d_ack", 64'(d_ack), (k % 2 == 0) ? 64'd0 : 64'd1);
            chk("rr_i_rdata", i_rdata, (k % 2 == 0) ? 64'hA000 + 64'(k) : 64'd0);
            chk("rr_d_rdata", d_rdata, (k % 2 == 0) ? 64'd0 : 64'hA000 + 64'(k));
            step();
            chk("rr_ack_width", 64'({i_ack, d_ack}), 64'd0);
        end
        i_req = 1'b0; d_req = 1'b0;

        // Store: fields held while memory is slow, d_rdata forced to 0
        d_req = 1'b1; d_we = 1'b1; d_word = 2'b00; d_addr = 64'h3; d_wdata = 64'hAB;
        step();
        chk("st_m_we",    64'(m_we),   64'd1);
        chk("st_m_word",  64'(m_word), 64'd0);
        chk("st_m_addr",  m_addr,      64'h3);
        chk("st_m_wdata", m_wdata,     64'hAB);
        d_wdata = 64'hFF; d_addr = 64'h7;
        step();
        chk("st_m_wdata_hold", m_wdata, 64'hAB);
        chk("st_m_addr_hold",  m_addr,  64'h3);
        chk("st_m_we_hold",    64'(m_we), 64'd1);
        m_ack = 1'b1; m_rdata = 64'hDEAD;
        step();
        m_ack = 1'b0;
        chk("st_d_ack",   64'(d_ack), 64'd1);
        chk("st_d_rdata", d_rdata,    64'd0);
        chk("st_d_err",   64'(d_err), 64'd0);
        chk("st_i_ack",   64'(i_ack), 64'd0);
        d_req = 1'b0; d_we = 1'b0;
        step();

        // Timeout on a fetch, then a normal data load
        i_req = 1'b1; i_addr = 64'h4000;
        step();
        busy_cycles = 0;
        while (m_req === 1'b1 && busy_cycles < 20) begin
            busy_cycles++;
            step();
        end
        chk("to_busy_cycles", 64'(busy_cycles), 64'd5);
        chk("to_i_ack",   64'(i_ack), 64'd1);
        chk("to_i_err",   64'(i_err), 64'd1);
        chk("to_i_rdata", i_rdata,    64'd0);
        i_req = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_word = 2'b10; d_addr = 64'h5000;
        step();
        step();
        chk("to_d_m_addr", m_addr, 64'h5000);
        m_ack = 1'b1; m_rdata = 64'h55;
        step();
        m_ack = 1'b0;
        chk("to_d_ack",   64'(d_ack), 64'd1);
        chk("to_d_rdata", d_rdata,    64'h55);
        chk("to_d_err",   64'(d_err), 64'd0);
        d_req = 1'b0;
        step();

        // Reset in second BUSY cycle of a load; late m_ack ignored
        d_req = 1'b1; d_addr = 64'h6000;
        step();
        step();
        chk("mr_busy2_m_req", 64'(m_req), 64'd1);
        rst = 1'b1;
        step();
        chk("mr_m_req", 64'(m_req), 64'd0);
        chk("mr_d_ack", 64'(d_ack), 64'd0);
        rst = 1'b0; m_ack = 1'b1; m_rdata = 64'h99;
        i_req = 1'b1; i_addr = 64'h1000;
        step();
        m_ack = 1'b0;
        chk("mr_no_d_ack",   64'(d_ack), 64'd0);
        chk("mr_no_i_ack",   64'(i_ack), 64'd0);
        chk("mr_tie_grant_i", m_addr,    64'h1000);
        step();
        chk("mr_still_busy", 64'(m_req), 64'd1);
        m_ack = 1'b1; m_rdata = 64'h77;
        step();
        m_ack = 1'b0;
        chk("mr_i_ack",   64'(i_ack), 64'd1);
        chk("mr_i_rdata", i_rdata,    64'h77);
        i_req = 1'b0; d_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
